spart_ctrl: RTL and testbench
=============================

# spart_ctrl

Bus-side controller for the SPART serial port. After reset it programs the baud divisor, then owns the SPART processor bus (`iocs`/`iorw`/`ioaddr`/`databus`). It schedules transmit writes from a small TX FIFO and captures received bytes into a one-entry RX holding register. It sits between the SPART instance and any host logic, so that logic sees only ready/valid streams.

## Interface

**Parameters**
- `DIV_INIT`, default `16'd325`: baud divisor written after reset (50 MHz, 9600 baud, 16x).
- `TXQ_DEPTH`, default `4`: TX FIFO entries; must be a power of two, at least 2.

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `tx_valid` in 1, `tx_data` in 8, `tx_ready` out 1: host transmit stream; `tx_ready` = FIFO not full.
- `rx_valid` out 1, `rx_data` out 8, `rx_ready` in 1: host receive stream.
- `rx_ovr` out 1: sticky overrun flag.
- `cfg_wr` in 1, `cfg_div` in 16: request to reprogram the divisor.
- `iocs` out 1, `iorw` out 1 (1 = read), `ioaddr` out 2: SPART bus control.
- `databus` inout 8: SPART data bus.
- `rda` in 1, `tbr` in 1: SPART status.

## Operation

**SPART bus map**
- `00`: TX write / RX read.
- `01`: status (unused).
- `10`: divisor low byte.
- `11`: divisor high byte.

**Bus rules**
- Idle drive is `iocs`=0, `iorw`=1, `ioaddr`=00, and `databus` is high-Z.
- `databus` is driven only in a write cycle (`iocs`=1, `iorw`=0).

**Read priority**
- `rda`=1 has absolute priority in every state.
- That cycle is a read: `iocs`=1, `iorw`=1, `ioaddr`=00, no `databus` drive.
- `databus` is sampled at the clock edge into `rx_data`, and `rx_valid`<=1.
- The FSM holds its state, so any write planned for that cycle slips by one cycle.
- This is a combinational path from `rda` to the bus outputs.

**FSM states**
- CFG_LO: write divisor low byte to `10`, go to CFG_HI.
- CFG_HI: write divisor high byte to `11`, go to IDLE.
- IDLE, first match wins:
  - pending config goes to CFG_LO;
  - otherwise, FIFO non-empty and `tbr`=1 goes to TX_WR;
  - otherwise, stay.
- TX_WR: write the FIFO head to `00`, pop the FIFO, go to TX_WAIT.
- TX_WAIT: stay until `tbr`=1, then go to IDLE.

**Configuration requests**
- The divisor register loads `DIV_INIT` on reset.
- `cfg_wr` loads `cfg_div` and sets cfg-pending in any state. A later `cfg_wr` overwrites the value.
- Pending is cleared on entry to CFG_LO.

**TX FIFO**
- Push when `tx_valid`&`tx_ready`.
- Simultaneous push and pop is allowed, and the count stays unchanged.
- Pointers are `$clog2(TXQ_DEPTH)` bits and wrap naturally; the count is one bit wider.

**RX holding register**
- A handshake (`rx_valid`&`rx_ready`) clears `rx_valid`.
- A capture while `rx_valid`=1 and no handshake that cycle overwrites `rx_data` and sets `rx_ovr`.
- A capture together with a handshake is not an overrun; `rx_valid` stays 1.
- `rx_ovr` clears on the next handshake after it was set, unless a new overrun happens in that same cycle.

## Timing

**Reset values**
- State = CFG_LO.
- `iocs`=0, `iorw`=1, `ioaddr`=00, `databus`=Z.
- `tx_ready`=1 (FIFO empty), `rx_valid`=0, `rx_data`=00, `rx_ovr`=0.

**Latencies**
- First bus write happens in the first cycle after `rst` deasserts, unless `rda`=1.
- Divisor programming takes 2 cycles.
- Host push to the SPART write takes at least 2 cycles: FIFO write, then IDLE decision, then TX_WR.
- The `rda` cycle to `rx_valid`=1 is 1 edge.
- TX_WAIT lasts at least 1 cycle, because `tbr` falls at the edge of the write.

**Mid-operation events**
- Reset mid-operation restarts at CFG_LO with `DIV_INIT`, and FIFO contents are discarded.
- `cfg_wr` during TX_WAIT is applied only after `tbr`=1, so no frame is cut.

## Configuration

- Macro `SPART_CTRL_ECHO_EN`.
- When defined: every captured RX byte is also pushed into the TX FIFO (loopback echo).
  - Echo wins over a host push in the same cycle; `tx_ready` is forced to 0 that cycle.
  - If the FIFO is full, the echo byte is dropped and `rx_ovr` is set.
- When undefined: no echo path, and `tx_ready` depends only on FIFO fullness.

## Structure

- Package `spart_pkg`:
  - address constants `SPART_ADDR_DATA`=2'b00, `SPART_ADDR_STAT`=2'b01, `SPART_ADDR_DBL`=2'b10, `SPART_ADDR_DBH`=2'b11;
  - FSM enum `spart_ctrl_state_t` (CFG_LO, CFG_HI, IDLE, TX_WR, TX_WAIT).
- One sub-module: `spart_txq`, a synchronous FIFO parameterised by width and depth, with push/pop/full/empty outputs.

## Test plan

1. Reset with `rda`=0 → cycle 1 writes 0x45 to addr `10`, cycle 2 writes 0x01 to addr `11`; `databus`=Z afterwards.
2. Push 0x41, 0x42 with `tbr`=1 → 0x41 written to `00`. 0x42 is written only after the model's `tbr` returns high; `tx_ready` stays 1.
3. Push 5 bytes with `TXQ_DEPTH`=4 and `tbr` held 0 → `tx_ready`=0 after 4 pushes, and the fifth is held by the host.
4. `rda` pulse with the model driving 0x5A while in CFG_HI → read cycle seen, `rx_data`=0x5A, and the CFG_HI write occurs one cycle later.
5. Two `rda` captures (0x11, 0x22) with `rx_ready`=0 → `rx_data`=0x22, `rx_ovr`=1. After one handshake, `rx_valid`=0 and `rx_ovr`=0.
6. `cfg_wr` with `cfg_div`=0x0028 during TX_WAIT → writes 0x28/0x00 occur only after `tbr`=1, before any queued TX byte.

Source files
------------

// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - SPART bus address map and controller state encoding
package spart_pkg;

  localparam logic [1:0] SPART_ADDR_DATA = 2'b00;
  localparam logic [1:0] SPART_ADDR_STAT = 2'b01;
  localparam logic [1:0] SPART_ADDR_DBL  = 2'b10;
  localparam logic [1:0] SPART_ADDR_DBH  = 2'b11;

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    IDLE,
    TX_WR,
    TX_WAIT
  } spart_ctrl_state_t;

endpackage

// File: rtl/spart_txq.sv
// rtl/spart_txq.sv - synchronous FIFO for transmit bytes awaiting the SPART
module spart_txq #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/spart_ctrl.sv
// rtl/spart_ctrl.sv - SPART bus controller: divisor setup, TX FIFO scheduling, RX holding register
// Optional loopback echo of received bytes: define SPART_CTRL_ECHO_EN.
module spart_ctrl #(
  parameter logic [15:0] DIV_INIT  = 16'd325,
  parameter int          TXQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        rx_ovr,
  input  logic        cfg_wr,
  input  logic [15:0] cfg_div,
  output logic        iocs,
  output logic        iorw,
  output logic [1:0]  ioaddr,
  inout  wire  [7:0]  databus,
  input  logic        rda,
  input  logic        tbr
);

  import spart_pkg::*;

  spart_ctrl_state_t state_q, state_d;
  logic [15:0] div_q, div_d;
  logic        cfg_pend_q, cfg_pend_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_ovr_q, rx_ovr_d;

  logic        bus_oe;
  logic [7:0]  bus_out;
  logic        capture, handshake, echo_drop;
  logic        q_push, q_pop, q_full, q_empty;
  logic [7:0]  q_push_data, q_head;

  assign databus   = bus_oe ? bus_out : 8'hzz;
  assign capture   = rda && !rst;
  assign handshake = rx_valid_q && rx_ready;

`ifdef SPART_CTRL_ECHO_EN
  // The echoed byte owns the FIFO write port in a capture cycle.
  assign tx_ready    = !q_full && !capture;
  assign q_push      = capture ? !q_full : (tx_valid && !q_full);
  assign q_push_data = capture ? databus : tx_data;
  assign echo_drop   = capture && q_full;
`else
  assign tx_ready    = !q_full;
  assign q_push      = tx_valid && !q_full;
  assign q_push_data = tx_data;
  assign echo_drop   = 1'b0;
`endif

  spart_txq #(
    .WIDTH (8),
    .DEPTH (TXQ_DEPTH)
  ) u_txq (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

  // A read for rda pre-empts the state's bus cycle; the state simply holds.
  always_comb begin
    state_d    = state_q;
    cfg_pend_d = cfg_pend_q;
    div_d      = div_q;
    iocs       = 1'b0;
    iorw       = 1'b1;
    ioaddr     = SPART_ADDR_DATA;
    bus_oe     = 1'b0;
    bus_out    = 8'h00;
    q_pop      = 1'b0;
    if (capture) begin
      iocs = 1'b1;
    end else if (!rst) begin
      case (state_q)
        CFG_LO: begin
          iocs    = 1'b1;
          iorw    = 1'b0;
          ioaddr  = SPART_ADDR_DBL;
          bus_oe  = 1'b1;
          bus_out = div_q[7:0];
          state_d = CFG_HI;
        end
        CFG_HI: begin
          iocs    = 1'b1;
          iorw    = 1'b0;
          ioaddr  = SPART_ADDR_DBH;
          bus_oe  = 1'b1;
          bus_out = div_q[15:8];
          state_d = IDLE;
        end
        IDLE: begin
          if (cfg_pend_q) begin
            state_d    = CFG_LO;
            cfg_pend_d = 1'b0;
          end else if (!q_empty && tbr) begin
            state_d = TX_WR;
          end
        end
        TX_WR: begin
          iocs    = 1'b1;
          iorw    = 1'b0;
          ioaddr  = SPART_ADDR_DATA;
          bus_oe  = 1'b1;
          bus_out = q_head;
          q_pop   = 1'b1;
          state_d = TX_WAIT;
        end
        TX_WAIT: begin
          if (tbr) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // A request arriving as CFG_LO is entered still leaves pending set, so it is never lost.
    if (cfg_wr) begin
      div_d      = cfg_div;
      cfg_pend_d = 1'b1;
    end
  end

  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    rx_ovr_d   = rx_ovr_q;
    if (capture) begin
      rx_valid_d = 1'b1;
      rx_data_d  = databus;
    end else if (handshake) begin
      rx_valid_d = 1'b0;
    end
    if ((capture && rx_valid_q && !handshake) || echo_drop) begin
      rx_ovr_d = 1'b1;
    end else if (handshake) begin
      rx_ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CFG_LO;
      div_q      <= DIV_INIT;
      cfg_pend_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_ovr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cfg_pend_q <= cfg_pend_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign rx_ovr   = rx_ovr_q;

endmodule

// File: tb/tb_spart_ctrl.sv
// tb/tb_spart_ctrl.sv - self-checking bench for spart_ctrl: vector table, directed sequences, random traffic
module tb_spart_ctrl;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic        rst, tx_valid, rx_ready, cfg_wr, rda, tbr;
  logic [7:0]  tx_data, rd_byte;
  logic [15:0] cfg_div;
  logic        tx_ready, rx_valid, rx_ovr, iocs, iorw;
  logic [7:0]  rx_data;
  logic [1:0]  ioaddr;
  wire  [7:0]  databus;

  // SPART side: returns rd_byte on reads; the bus floats high when nobody drives it.
  assign databus = (iocs && iorw) ? rd_byte : 8'hzz;
  for (genvar gi = 0; gi < 8; gi++) begin : g_pu
    pullup (databus[gi]);
  end

  spart_ctrl #(.DIV_INIT(16'd325), .TXQ_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .rx_ovr(rx_ovr),
    .cfg_wr(cfg_wr), .cfg_div(cfg_div),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
    .rda(rda), .tbr(tbr)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  logic       s_cs, s_rw, s_txr;
  logic [1:0] s_addr;
  logic [7:0] s_bus;
  logic [9:0] wr_log[$];

  task automatic tick();
    @(negedge clk);
    s_cs   = iocs;
    s_rw   = iorw;
    s_addr = ioaddr;
    s_bus  = databus;
    s_txr  = tx_ready;
    if (iocs && !iorw) wr_log.push_back({ioaddr, databus});
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst, rda, tbr, txv;
    logic [7:0] txd, rdb;
    logic       rxr;
    logic       e_cs, e_rw;
    logic [1:0] e_addr;
    logic [7:0] e_bus;
    logic       e_rxv;
    logic [7:0] e_rxd;
    logic       e_ovr;
  } vec_t;

  function automatic vec_t v(input logic r, input logic a, input logic t, input logic x,
                             input logic [7:0] xd, input logic [7:0] rb, input logic rr,
                             input logic cs, input logic rw, input logic [1:0] ad,
                             input logic [7:0] bu, input logic rv, input logic [7:0] rd,
                             input logic ov);
    vec_t e;
    e.rst = r; e.rda = a; e.tbr = t; e.txv = x; e.txd = xd; e.rdb = rb; e.rxr = rr;
    e.e_cs = cs; e.e_rw = rw; e.e_addr = ad; e.e_bus = bu;
    e.e_rxv = rv; e.e_rxd = rd; e.e_ovr = ov;
    return e;
  endfunction

  vec_t       tbl[$];
  logic [7:0] exp_q[$];
  logic [9:0] exp6[6];
  logic       m_rxv, m_ovr, hs, ovr_new, cur_tbr;
  logic [7:0] m_rxd;
  int         acc, tbr_wait;

  // Data writes must drain the host's bytes in order, only while tbr is high.
  task automatic wr_check();
    if (s_cs && !s_rw) begin
      chk("wr_addr", s_addr, 2'b00);
      chk("wr_tbr", cur_tbr, 1'b1);
      chk("wr_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) chk("wr_data", s_bus, exp_q.pop_front());
      tbr      = 1'b0;
      tbr_wait = $urandom_range(1, 4);
    end else if (!tbr) begin
      tbr_wait--;
      if (tbr_wait <= 0) tbr = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0; cfg_wr = 1'b0;
    cfg_div = 16'h0000; rda = 1'b0; tbr = 1'b1; rd_byte = 8'h00;

    //             rst rda tbr txv txd    rdb    rxr  cs rw addr bus    rxv rxd    ovr
    tbl.push_back(v(1, 0, 1, 0, 8'h00, 8'h00, 0,   0, 1, 2'd0, 8'hFF, 0, 8'h00, 0));
    tbl.push_back(v(1, 0, 1, 0, 8'h00, 8'h00, 0,   0, 1, 2'd0, 8'hFF, 0, 8'h00, 0));
    tbl.push_back(v(0, 0, 1, 0, 8'h00, 8'h00, 0,   1, 0, 2'd2, 8'h45, 0, 8'h00, 0));
    tbl.push_back(v(0, 0, 1, 0, 8'h00, 8'h00, 0,   1, 0, 2'd3, 8'h01, 0, 8'h00, 0));
    tbl.push_back(v(0, 0, 1, 1, 8'h41, 8'h00, 0,   0, 1, 2'd0, 8'hFF, 0, 8'h00, 0));
    tbl.push_back(v(0, 0, 1, 1, 8'h42, 8'h00, 0,   0, 1, 2'd0, 8'hFF, 0, 8'h00, 0));
    tbl.push_back(v(0, 0, 1, 0, 8'h00, 8'h00, 0,   1, 0, 2'd0, 8'h41, 0, 8'h00, 0));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, 0,   0, 1, 2'd0, 8'hFF, 0, 8'h00, 0));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, 0,   0, 1, 2'd0, 8'hFF, 0, 8'h00, 0));
    tbl.push_back(v(0, 0, 1, 0, 8'h00, 8'h00, 0,   0, 1, 2'd0, 8'hFF, 0, 8'h00, 0));
    tbl.push_back(v(0, 0, 1, 0, 8'h00, 8'h00, 0,   0, 1, 2'd0, 8'hFF, 0, 8'h00, 0));
    tbl.push_back(v(0, 0, 1, 0, 8'h00, 8'h00, 0,   1, 0, 2'd0, 8'h42, 0, 8'h00, 0));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, 0,   0, 1, 2'd0, 8'hFF, 0, 8'h00, 0));
    tbl.push_back(v(1, 0, 1, 0, 8'h00, 8'h00, 0,   0, 1, 2'd0, 8'hFF, 0, 8'h00, 0));
    tbl.push_back(v(0, 0, 1, 0, 8'h00, 8'h00, 0,   1, 0, 2'd2, 8'h45, 0, 8'h00, 0));
    tbl.push_back(v(0, 1, 1, 0, 8'h00, 8'h5A, 0,   1, 1, 2'd0, 8'h5A, 1, 8'h5A, 0));
    tbl.push_back(v(0, 0, 1, 0, 8'h00, 8'h00, 0,   1, 0, 2'd3, 8'h01, 1, 8'h5A, 0));
    tbl.push_back(v(0, 0, 1, 0, 8'h00, 8'h00, 1,   0, 1, 2'd0, 8'hFF, 0, 8'h5A, 0));
    tbl.push_back(v(0, 1, 1, 0, 8'h00, 8'h11, 0,   1, 1, 2'd0, 8'h11, 1, 8'h11, 0));
    tbl.push_back(v(0, 1, 1, 0, 8'h00, 8'h22, 0,   1, 1, 2'd0, 8'h22, 1, 8'h22, 1));
    tbl.push_back(v(0, 0, 1, 0, 8'h00, 8'h00, 1,   0, 1, 2'd0, 8'hFF, 0, 8'h22, 0));
    tbl.push_back(v(0, 0, 1, 0, 8'h00, 8'h00, 0,   0, 1, 2'd0, 8'hFF, 0, 8'h22, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; rda = tbl[i].rda; tbr = tbl[i].tbr; tx_valid = tbl[i].txv;
      tx_data = tbl[i].txd; rd_byte = tbl[i].rdb; rx_ready = tbl[i].rxr;
      tick();
      chk($sformatf("v%0d.iocs", i), s_cs, tbl[i].e_cs);
      chk($sformatf("v%0d.iorw", i), s_rw, tbl[i].e_rw);
      chk($sformatf("v%0d.ioaddr", i), s_addr, tbl[i].e_addr);
      chk($sformatf("v%0d.databus", i), s_bus, tbl[i].e_bus);
      chk($sformatf("v%0d.tx_ready", i), s_txr, 1'b1);
      chk($sformatf("v%0d.rx_valid", i), rx_valid, tbl[i].e_rxv);
      chk($sformatf("v%0d.rx_data", i), rx_data, tbl[i].e_rxd);
      chk($sformatf("v%0d.rx_ovr", i), rx_ovr, tbl[i].e_ovr);
    end

    // Fill the FIFO against a busy transmitter, then reprogram during TX_WAIT.
    rda = 1'b0; rx_ready = 1'b1; tx_valid = 1'b0; tbr = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    wr_log.delete();
    acc = 0;
    tx_valid = 1'b1;
    tx_data  = 8'hA0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (s_txr) begin
        acc++;
        tx_data = tx_data + 8'h01;
      end
    end
    chk("fill_accepted", acc, 4);
    chk("fill_ready_low", s_txr, 1'b0);
    chk("fill_no_write", wr_log.size(), 0);
    tx_valid = 1'b0;
    tbr = 1'b1;
    tick();
    tick();
    tbr = 1'b0;
    tick();
    cfg_wr  = 1'b1;
    cfg_div = 16'h0028;
    tick();
    cfg_wr = 1'b0;
    tick();
    tick();
    tick();
    chk("txwait_hold", wr_log.size(), 1);
    tbr = 1'b1;
    for (int c = 0; c < 60 && wr_log.size() < 6; c++) begin
      tick();
      tbr = !(s_cs && !s_rw && s_addr == 2'b00);
    end
    exp6 = '{10'h0A0, 10'h228, 10'h300, 10'h0A1, 10'h0A2, 10'h0A3};
    chk("seq_len", wr_log.size(), 6);
    for (int i = 0; i < 6 && i < wr_log.size(); i++) begin
      chk($sformatf("seq_wr%0d", i), wr_log[i], exp6[i]);
    end

    // Reset with bytes still queued: they must never reach the bus.
    tbr = 1'b0;
    tx_valid = 1'b1;
    tx_data = 8'hEE;
    tick();
    tick();
    tx_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tbr = 1'b1;
    wr_log.delete();
    tick();
    chk("rst_tx_ready", s_txr, 1'b1);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_ovr", rx_ovr, 1'b0);
    tick();
    chk("rst_cfg_len", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("rst_cfg_lo", wr_log[0], 10'h245);
      chk("rst_cfg_hi", wr_log[1], 10'h301);
    end

    // Random traffic against a transaction-level model.
    exp_q.delete();
    m_rxv = 1'b0; m_rxd = 8'h00; m_ovr = 1'b0;
    tbr_wait = 0;
    for (int c = 0; c < 3000; c++) begin
      tx_valid = ($urandom_range(0, 2) != 0);
      tx_data  = 8'($urandom);
      rda      = ($urandom_range(0, 7) == 0);
      rd_byte  = 8'($urandom);
      rx_ready = 1'($urandom);
      cur_tbr  = tbr;
      tick();
      if (rda) begin
        chk("rd_ctrl", {s_cs, s_rw, s_addr}, 4'b1100);
        chk("rd_bus", s_bus, rd_byte);
      end else if (!(s_cs && !s_rw)) begin
        chk("idle_cs", s_cs, 1'b0);
      end
      chk("tx_ready", s_txr, exp_q.size() < 4);
      wr_check();
      if (tx_valid && s_txr) exp_q.push_back(tx_data);
      hs = m_rxv && rx_ready;
      ovr_new = rda && m_rxv && !hs;
      if (rda) begin
        m_rxv = 1'b1;
        m_rxd = rd_byte;
      end else if (hs) begin
        m_rxv = 1'b0;
      end
      if (ovr_new) m_ovr = 1'b1;
      else if (hs) m_ovr = 1'b0;
      chk("rx_valid", rx_valid, m_rxv);
      chk("rx_data", rx_data, m_rxd);
      chk("rx_ovr", rx_ovr, m_ovr);
    end

    tx_valid = 1'b0;
    rda = 1'b0;
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin
      cur_tbr = tbr;
      tick();
      wr_check();
    end
    chk("drain_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
